// File: rtl/pc_fetch_unit_if.sv
// ---------------------------------------------------------------------------
// pc_fetch_unit_if
// Groups the fetch unit's two handshakes into one bundle:
//   * instruction-memory side : imem_req/imem_addr (to memory),
//                               imem_ready/imem_rdata (from memory)
//   * downstream side         : instr_valid/instr/instr_pc (to decode),
//                               instr_ready (from decode)
// master : the fetch unit.
// slave  : the memory plus downstream consumer (e.g. a testbench).
// ---------------------------------------------------------------------------
interface pc_fetch_unit_if #(
    parameter int INSTR_W = 32
);
    logic               imem_req;
    logic [19:0]        imem_addr;
    logic               imem_ready;
    logic [INSTR_W-1:0] imem_rdata;
    logic               instr_valid;
    logic               instr_ready;
    logic [INSTR_W-1:0] instr;
    logic [19:0]        instr_pc;

    modport master (
        output imem_req, imem_addr, instr_valid, instr, instr_pc,
        input  imem_ready, imem_rdata, instr_ready
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instr, instr_pc,
        output imem_ready, imem_rdata, instr_ready
    );
endinterface

// File: rtl/pc_fetch_unit.sv
// ---------------------------------------------------------------------------
// pc_fetch_unit
// Sequential instruction fetch with branch redirect.  A three-state machine
// (IDLE -> REQ -> HOLD) issues one memory request at a time, parks the
// returned word in an output register until downstream takes it, and then
// issues the next request.  A redirect that arrives while a request is in
// flight cannot cancel the memory transaction, so it is remembered in a
// kill flag/target pair and the eventual response is dropped.
//
// Ports
//   clk, rst_n     : clock, asynchronous active-low reset
//   branch_taken   : redirect request, sampled every cycle
//   branch_target  : redirect address
//   stall          : blocks issue of new fetches
//   pc             : current architectural fetch PC
//   bus (master)   : imem_req/imem_addr/imem_ready/imem_rdata and
//                    instr_valid/instr_ready/instr/instr_pc
// ---------------------------------------------------------------------------
module pc_fetch_unit #(
    parameter logic [19:0] RESET_PC = 20'h00000,
    parameter int          INSTR_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              branch_taken,
    input  logic [19:0]       branch_target,
    input  logic              stall,
    output logic [19:0]       pc,
    pc_fetch_unit_if.master   bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t             state_q,        state_d;
    logic [19:0]        pc_q,           pc_d;
    logic [INSTR_W-1:0] instr_q,        instr_d;
    logic [19:0]        instr_pc_q,     instr_pc_d;
    logic               kill_q,         kill_d;
    logic [19:0]        kill_target_q,  kill_target_d;
    logic               imem_req_q,     imem_req_d;
    logic               instr_valid_q,  instr_valid_d;

    // Next-state, PC and output-register computation for the fetch FSM.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        kill_d        = kill_q;
        kill_target_d = kill_target_q;

        case (state_q)
            ST_IDLE: begin
                // A redirect wins over stall so the new stream starts at once.
                if (branch_taken) begin
                    pc_d    = branch_target;
                    state_d = ST_REQ;
                end else if (!stall) begin
                    state_d = ST_REQ;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_REQ: begin
                if (kill_q) begin
                    // Request already doomed: a newer redirect replaces the target.
                    if (branch_taken) begin
                        kill_target_d = branch_target;
                    end else begin
                        kill_target_d = kill_target_q;
                    end
                    if (bus.imem_ready) begin
                        pc_d   = branch_taken ? branch_target : kill_target_q;
                        kill_d = 1'b0;
                    end else begin
                        kill_d = 1'b1;
                    end
                    state_d = ST_REQ;
                end else if (branch_taken) begin
                    // pc must stay put while memory is busy so imem_addr holds.
                    if (bus.imem_ready) begin
                        pc_d = branch_target;
                    end else begin
                        kill_d        = 1'b1;
                        kill_target_d = branch_target;
                    end
                    state_d = ST_REQ;
                end else if (bus.imem_ready) begin
                    instr_d    = bus.imem_rdata;
                    instr_pc_d = pc_q;
                    pc_d       = pc_q + 20'd1;
                    state_d    = ST_HOLD;
                end else begin
                    state_d = ST_REQ;
                end
            end

            ST_HOLD: begin
                if (branch_taken) begin
                    pc_d    = branch_target;
                    state_d = ST_REQ;
                end else if (bus.instr_ready) begin
                    state_d = stall ? ST_IDLE : ST_REQ;
                end else begin
                    state_d = ST_HOLD;
                end
            end

            default: begin
                state_d = ST_IDLE;
                kill_d  = 1'b0;
            end
        endcase

        // Outputs are registered from the next state so they line up with it.
        imem_req_d    = (state_d == ST_REQ);
        instr_valid_d = (state_d == ST_HOLD);
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            pc_q          <= RESET_PC;
            instr_q       <= {INSTR_W{1'b0}};
            instr_pc_q    <= 20'h00000;
            kill_q        <= 1'b0;
            kill_target_q <= 20'h00000;
            imem_req_q    <= 1'b0;
            instr_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            kill_q        <= kill_d;
            kill_target_q <= kill_target_d;
            imem_req_q    <= imem_req_d;
            instr_valid_q <= instr_valid_d;
        end
    end

    // The request address is the PC itself; pc only moves on a completed
    // fetch or redirect, which keeps the address stable during a wait.
    assign pc              = pc_q;
    assign bus.imem_req    = imem_req_q;
    assign bus.imem_addr   = pc_q;
    assign bus.instr_valid = instr_valid_q;
    assign bus.instr       = instr_q;
    assign bus.instr_pc    = instr_pc_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_pc_fetch_unit
// Self-checking bench for pc_fetch_unit.  A transaction-level model tracks
// "request outstanding", "instruction held", and "response to be dropped",
// and predicts every output at each negative clock edge.  Directed
// scenarios pin the model with literal expectations, then a randomized run
// exercises redirects, stalls and back-pressure.
// ---------------------------------------------------------------------------
module tb_pc_fetch_unit;
    localparam int W = 32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        branch_taken = 1'b0;
    logic [19:0] branch_target = 20'h00000;
    logic        stall = 1'b0;
    logic [19:0] pc;

    pc_fetch_unit_if #(.INSTR_W(W)) bus ();

    pc_fetch_unit #(.RESET_PC(20'h00000), .INSTR_W(W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .stall         (stall),
        .pc            (pc),
        .bus           (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model state.
    bit          m_out;        // a memory request is outstanding
    bit          m_have;       // an instruction is held for downstream
    bit          m_drop;       // current response must be thrown away
    logic [19:0] m_drop_tgt;
    logic [19:0] m_pc;
    logic [19:0] m_instr_pc;
    logic [31:0] m_instr;

    function automatic logic [31:0] mem_word(input logic [19:0] a);
        return {a[11:0], a} ^ 32'h5A3C_96E1;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_out = 1'b0; m_have = 1'b0; m_drop = 1'b0;
        m_drop_tgt = 20'h00000; m_pc = 20'h00000;
        m_instr_pc = 20'h00000; m_instr = 32'h0;
    endtask

    task automatic model_step(input bit bt, input logic [19:0] tgt, input bit st,
                              input bit rdy, input bit ir);
        if (m_out) begin
            if (m_drop) begin
                if (bt) m_drop_tgt = tgt;
                if (rdy) begin
                    m_pc   = m_drop_tgt;
                    m_drop = 1'b0;
                end
            end else if (bt) begin
                if (rdy) m_pc = tgt;
                else begin
                    m_drop     = 1'b1;
                    m_drop_tgt = tgt;
                end
            end else if (rdy) begin
                m_instr    = mem_word(m_pc);
                m_instr_pc = m_pc;
                m_pc       = (m_pc + 20'd1) & 20'hFFFFF;
                m_out      = 1'b0;
                m_have     = 1'b1;
            end
        end else if (m_have) begin
            if (bt) begin
                m_pc = tgt; m_have = 1'b0; m_out = 1'b1;
            end else if (ir) begin
                m_have = 1'b0; m_out = !st;
            end
        end else begin
            if (bt) begin
                m_pc = tgt; m_out = 1'b1;
            end else if (!st) begin
                m_out = 1'b1;
            end
        end
    endtask

    task automatic compare_all();
        chk("imem_req", bus.imem_req, m_out);
        if (m_out) chk("imem_addr", bus.imem_addr, m_pc);
        chk("instr_valid", bus.instr_valid, m_have);
        chk("instr", bus.instr, m_instr);
        chk("instr_pc", bus.instr_pc, m_instr_pc);
        chk("pc", pc, m_pc);
    endtask

    // Apply inputs at a negative edge, advance one clock, check at the next.
    task automatic cycle(input bit bt, input logic [19:0] tgt, input bit st,
                         input bit rdy, input bit ir);
        branch_taken    = bt;
        branch_target   = tgt;
        stall           = st;
        bus.imem_ready  = rdy;
        bus.instr_ready = ir;
        bus.imem_rdata  = rdy ? mem_word(m_pc) : $urandom;
        model_step(bt, tgt, st, rdy, ir);
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_imem_req"}, bus.imem_req, 1'b0);
        chk({tag, "_imem_addr"}, bus.imem_addr, 20'h00000);
        chk({tag, "_instr_valid"}, bus.instr_valid, 1'b0);
        chk({tag, "_instr"}, bus.instr, 32'h0);
        chk({tag, "_instr_pc"}, bus.instr_pc, 20'h00000);
        chk({tag, "_pc"}, pc, 20'h00000);
    endtask

    // Reset held over two edges with a stray imem_ready that must be ignored.
    task automatic hold_reset_and_release();
        bus.imem_ready  = 1'b1;
        bus.imem_rdata  = $urandom;
        branch_taken    = 1'b0;
        stall           = 1'b0;
        bus.instr_ready = 1'b1;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_reset_values("in_reset");
        rst_n = 1'b1;
        compare_all();
    endtask

    initial begin
        bus.imem_ready  = 1'b0;
        bus.imem_rdata  = 32'h0;
        bus.instr_ready = 1'b0;
        model_reset();

        @(negedge clk);
        rst_n = 1'b0;
        #1 check_reset_values("por");
        hold_reset_and_release();

        // Straight-line fetch: addresses 0,1,2 with instr_pc one step behind.
        cycle(1'b0, 20'h0, 1'b0, 1'b1, 1'b1);
        chk("seq_req0", bus.imem_req, 1'b1);
        chk("seq_addr0", bus.imem_addr, 20'h00000);
        cycle(1'b0, 20'h0, 1'b0, 1'b1, 1'b1);
        chk("seq_valid0", bus.instr_valid, 1'b1);
        chk("seq_ipc0", bus.instr_pc, 20'h00000);
        chk("seq_instr0", bus.instr, 32'h5A3C96E1);
        cycle(1'b0, 20'h0, 1'b0, 1'b1, 1'b1);
        chk("seq_addr1", bus.imem_addr, 20'h00001);
        cycle(1'b0, 20'h0, 1'b0, 1'b1, 1'b1);
        chk("seq_ipc1", bus.instr_pc, 20'h00001);
        cycle(1'b0, 20'h0, 1'b0, 1'b1, 1'b1);
        chk("seq_addr2", bus.imem_addr, 20'h00002);

        // Redirect coinciding with a response, then fetch across the wrap.
        cycle(1'b1, 20'hFFFFF, 1'b0, 1'b1, 1'b1);
        chk("wrap_addr", bus.imem_addr, 20'hFFFFF);
        chk("wrap_novalid", bus.instr_valid, 1'b0);
        cycle(1'b0, 20'h0, 1'b0, 1'b1, 1'b0);
        chk("wrap_pc", pc, 20'h00000);
        chk("wrap_ipc", bus.instr_pc, 20'hFFFFF);

        // Redirect while memory is slow: address held, response dropped.
        cycle(1'b1, 20'h00010, 1'b0, 1'b0, 1'b0);
        chk("kill_addr_start", bus.imem_addr, 20'h00010);
        cycle(1'b1, 20'hABCDE, 1'b0, 1'b0, 1'b0);
        chk("kill_addr_hold1", bus.imem_addr, 20'h00010);
        cycle(1'b0, 20'h0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 20'h0, 1'b0, 1'b0, 1'b0);
        chk("kill_addr_hold3", bus.imem_addr, 20'h00010);
        cycle(1'b0, 20'h0, 1'b0, 1'b1, 1'b0);
        chk("kill_new_addr", bus.imem_addr, 20'hABCDE);
        chk("kill_no_valid", bus.instr_valid, 1'b0);
        chk("kill_req", bus.imem_req, 1'b1);

        // Back-pressure: held instruction stable for four cycles.
        cycle(1'b0, 20'h0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 20'h0, 1'b0, 1'($urandom_range(1, 0)), 1'b0);
            chk("bp_valid", bus.instr_valid, 1'b1);
            chk("bp_ipc", bus.instr_pc, 20'hABCDE);
        end
        cycle(1'b0, 20'h0, 1'b0, 1'b0, 1'b1);
        chk("bp_next_req", bus.imem_req, 1'b1);
        chk("bp_next_addr", bus.imem_addr, 20'hABCDF);

        // Stall takes the unit idle; a redirect overrides stall.
        cycle(1'b0, 20'h0, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 20'h0, 1'b1, 1'b1, 1'b1);
        chk("stall_idle_req", bus.imem_req, 1'b0);
        chk("stall_idle_valid", bus.instr_valid, 1'b0);
        cycle(1'b0, 20'h0, 1'b1, 1'b1, 1'b0);
        chk("stall_still_idle", bus.imem_req, 1'b0);
        cycle(1'b1, 20'h12345, 1'b1, 1'b0, 1'b0);
        chk("stall_branch_req", bus.imem_req, 1'b1);
        chk("stall_branch_addr", bus.imem_addr, 20'h12345);

        // Asynchronous reset in the middle of a request.
        #2 rst_n = 1'b0;
        #1 check_reset_values("async");
        hold_reset_and_release();
        cycle(1'b0, 20'h0, 1'b0, 1'b1, 1'b1);
        chk("restart_req", bus.imem_req, 1'b1);
        chk("restart_addr", bus.imem_addr, 20'h00000);
        chk("restart_novalid", bus.instr_valid, 1'b0);

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            logic [19:0] tgt;
            tgt = 20'($urandom);
            if ($urandom_range(7, 0) == 0) tgt = 20'hFFFFF - 20'($urandom_range(2, 0));
            cycle($urandom_range(7, 0) == 0, tgt, $urandom_range(3, 0) == 0,
                  $urandom_range(1, 0) == 1, $urandom_range(2, 0) != 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/pc_fetch_unit.md
PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 20'h00000: PC value loaded on reset.
REQ-002 Parameter INSTR_W, default 32: instruction word width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 branch_taken  input  1  redirect request from jump stage (JMP/JMPS decision), sampled each cycle.
REQ-006 branch_target  input  20  redirect address (jump stage new_pc), valid when branch_taken=1.
REQ-007 stall  input  1  freezes issue of new fetches.
REQ-008 imem_req  output  1  instruction-memory request.
REQ-009 imem_addr  output  20  fetch address; stable while imem_req=1 and imem_ready=0.
REQ-010 imem_ready  input  1  memory completes request this cycle; imem_rdata valid.
REQ-011 imem_rdata  input  INSTR_W  fetched instruction.
REQ-012 instr_valid  output  1  instr/instr_pc hold a valid fetched instruction.
REQ-013 instr_ready  input  1  downstream accepts instruction when instr_valid=1.
REQ-014 instr  output  INSTR_W  registered instruction.
REQ-015 instr_pc  output  20  address of instr.
REQ-016 pc  output  20  current architectural fetch PC.

Function
REQ-017 FSM states SHALL be IDLE, REQ, HOLD; encoding free.
REQ-018 IDLE: if stall=0, next state REQ; else remain IDLE.
REQ-019 REQ: imem_req=1, imem_addr=pc; on imem_ready=1 with no kill, latch imem_rdata->instr, pc->instr_pc, pc<=pc+1, go HOLD.
REQ-020 HOLD: instr_valid=1; on instr_ready=1 and stall=0, go REQ next cycle; on instr_ready=1 and stall=1, go IDLE; else remain HOLD with instr/instr_pc unchanged.
REQ-021 PC increment SHALL be +1 modulo 2^20 (20'hFFFFF wraps to 20'h00000).
REQ-022 Issue latency: first imem_req SHALL assert in the cycle after rst_n deassert (IDLE then REQ) when stall=0.
REQ-023 branch_taken in IDLE or HOLD: pc<=branch_target, instr_valid deasserts next cycle, state<=REQ (branch overrides stall and instr_ready).
REQ-024 branch_taken in REQ with imem_ready=0: imem_req/imem_addr SHALL stay unchanged; kill flag set, target stored; on later imem_ready, data discarded, pc<=stored target, stay REQ.
REQ-025 branch_taken in REQ with imem_ready=1 same cycle: data discarded, pc<=branch_target, stay REQ.
REQ-026 Second branch_taken while kill pending SHALL overwrite stored target (last wins).
REQ-027 Discarded responses SHALL never raise instr_valid.
REQ-028 pc output SHALL update only on successful fetch or redirect.

Reset
REQ-029 While rst_n=0: state=IDLE, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0, kill flag=0.
REQ-030 Reset asserted mid-request SHALL abandon the request immediately; a subsequent imem_ready before the first new imem_req is ignored.

Verification
REQ-031 Reset release, stall=0, imem_ready=1 every cycle, instr_ready=1 -> imem_addr sequence 0x00000, 0x00001, 0x00002; instr_pc follows one cycle after each.
REQ-032 pc=0xFFFFF fetch completes -> pc=0x00000, instr_pc=0xFFFFF.
REQ-033 In REQ at 0x00010, imem_ready low 3 cycles, branch_taken with target 0xABCDE in cycle 1 -> addr held 0x00010; response discarded; next imem_addr=0xABCDE; no instr_valid for 0x00010.
REQ-034 HOLD with instr_ready=0 for 4 cycles -> instr, instr_pc, instr_valid stable; then instr_ready=1 -> next request issued following cycle.
REQ-035 stall=1 during HOLD then instr_ready=1 -> IDLE, imem_req=0 until stall=0; stall=1 plus branch_taken -> redirect to target anyway.
REQ-036 rst_n pulsed low during REQ -> all outputs at REQ-029 values asynchronously; restart fetch at RESET_PC.
